// File: rtl/bp_be_pkg.sv
// Shared backend types for the stride prefetch issuer: configuration enum,
// FSM state encoding and the single-entry stride tracker record.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int bp_vaddr_width_gp = 39;
  localparam int bp_conf_width_gp  = 8;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    int w;
    case (cfg)
      e_bp_default_cfg: w = bp_vaddr_width_gp;
      default:          w = bp_vaddr_width_gp;
    endcase
    return w;
  endfunction

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_train = 2'd1,
    e_wait  = 2'd2,
    e_issue = 2'd3
  } bp_be_stride_state_e;

  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0] pc;
    logic [bp_vaddr_width_gp-1:0] last_addr;
    logic [bp_vaddr_width_gp-1:0] stride;
    logic [bp_conf_width_gp-1:0]  conf;
  } bp_be_stride_entry_s;

endpackage

// File: rtl/bp_be_stride_tracker.sv
// Single-entry stride trainer: stride subtract/compare, confidence counter
// and registered start/confirm discovery pulses.
module bp_be_stride_tracker
  import bp_be_pkg::*;
#(
  parameter int conf_threshold_p = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         init_i,
  input  logic                         train_en_i,
  input  logic                         track_en_i,
  input  logic [bp_vaddr_width_gp-1:0] ld_pc_i,
  input  logic [bp_vaddr_width_gp-1:0] ld_eaddr_i,
  output bp_be_stride_entry_s          entry_o,
  output logic                         pc_match_o,
  output logic                         confirm_now_o,
  output logic                         start_o,
  output logic                         confirm_o
);

  bp_be_stride_entry_s entry_q, entry_d;
  logic start_q, start_d;
  logic confirm_q, confirm_d;

  logic [bp_vaddr_width_gp-1:0] new_stride;
  logic [bp_conf_width_gp-1:0]  conf_inc;
  logic                         stride_repeat;

  assign new_stride    = ld_eaddr_i - entry_q.last_addr;
  assign conf_inc      = entry_q.conf + 1'b1;
  assign stride_repeat = (new_stride == entry_q.stride) && (new_stride != '0);
  assign pc_match_o    = (ld_pc_i == entry_q.pc);

  always_comb begin
    entry_d   = entry_q;
    start_d   = 1'b0;
    confirm_d = 1'b0;
    if (init_i) begin
      entry_d.pc        = ld_pc_i;
      entry_d.last_addr = ld_eaddr_i;
      entry_d.stride    = '0;
      entry_d.conf      = '0;
    end else if (train_en_i) begin
      entry_d.last_addr = ld_eaddr_i;
      if (stride_repeat) begin
        entry_d.conf = conf_inc;
        start_d      = (entry_q.conf == '0);
        confirm_d    = (conf_inc == bp_conf_width_gp'(conf_threshold_p));
      end else begin
        entry_d.stride = new_stride;
        entry_d.conf   = '0;
      end
    end else if (track_en_i) begin
      // Stride is frozen once confirmed; only the anchor address follows.
      entry_d.last_addr = ld_eaddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      entry_q   <= '0;
      start_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      entry_q   <= entry_d;
      start_q   <= start_d;
      confirm_q <= confirm_d;
    end
  end

  assign entry_o       = entry_q;
  assign confirm_now_o = confirm_d;
  assign start_o       = start_q;
  assign confirm_o     = confirm_q;

endmodule

// File: rtl/bp_be_stride_prefetch_issuer.sv
// Trains a stride on committed loads, runs the loop-trip discovery handshake
// and issues stride-ahead prefetches for the returned iteration estimate.
module bp_be_stride_prefetch_issuer
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_default_cfg,
  parameter int         iter_width_p     = 8,
  parameter int         conf_threshold_p = 3,
  parameter int         max_prefetch_p   = 32,
  parameter int         timeout_p        = 255,
  localparam int        vaddr_width_p    = bp_vaddr_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ld_v_i,
  input  logic [vaddr_width_p-1:0] ld_pc_i,
  input  logic [vaddr_width_p-1:0] ld_eaddr_i,
  output logic                     start_discovery_o,
  output logic                     confirm_discovery_o,
  output logic [vaddr_width_p-1:0] striding_pc_o,
  input  logic [iter_width_p-1:0]  remaining_iterations_i,
  input  logic                     v_i,
  output logic                     yumi_o,
  output logic                     pf_v_o,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  input  logic                     pf_ready_i
);

  localparam int cnt_w_lp   = $clog2(max_prefetch_p + 1);
  localparam int timer_w_lp = $clog2(timeout_p + 1);

  bp_be_stride_state_e state_q, state_d;
  logic [cnt_w_lp-1:0]      count_q, count_d;
  logic [timer_w_lp-1:0]    timer_q, timer_d;
  logic [vaddr_width_p-1:0] next_addr_q, next_addr_d;

  logic                init_en, train_en, track_en;
  logic                pc_match, confirm_now;
  bp_be_stride_entry_s entry;
  logic [cnt_w_lp-1:0] capped_count;

  bp_be_stride_tracker #(
    .conf_threshold_p(conf_threshold_p)
  ) tracker (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .init_i       (init_en),
    .train_en_i   (train_en),
    .track_en_i   (track_en),
    .ld_pc_i      (ld_pc_i),
    .ld_eaddr_i   (ld_eaddr_i),
    .entry_o      (entry),
    .pc_match_o   (pc_match),
    .confirm_now_o(confirm_now),
    .start_o      (start_discovery_o),
    .confirm_o    (confirm_discovery_o)
  );

  always_comb begin
    if (32'(remaining_iterations_i) > 32'(max_prefetch_p)) begin
      capped_count = cnt_w_lp'(max_prefetch_p);
    end else begin
      capped_count = cnt_w_lp'(remaining_iterations_i);
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    timer_d       = timer_q;
    next_addr_d   = next_addr_q;
    init_en       = 1'b0;
    train_en      = 1'b0;
    track_en      = 1'b0;
    yumi_o        = 1'b0;
    pf_v_o        = 1'b0;
    pf_addr_o     = '0;
    striding_pc_o = entry.pc;

    unique case (state_q)
      e_idle: begin
        striding_pc_o = '0;
        timer_d       = '0;
        if (ld_v_i) begin
          init_en = 1'b1;
          state_d = e_train;
        end
      end
      e_train: begin
        train_en = ld_v_i && pc_match;
        if (confirm_now) begin
          timer_d = '0;
          state_d = e_wait;
        end
      end
      e_wait: begin
        track_en = ld_v_i && pc_match;
        yumi_o   = v_i;
        // An estimate arriving on the final timeout cycle is still accepted.
        if (v_i) begin
          count_d     = capped_count;
          next_addr_d = entry.last_addr + entry.stride;
          state_d     = (capped_count == '0) ? e_idle : e_issue;
        end else if (timer_q == timer_w_lp'(timeout_p - 1)) begin
          state_d = e_idle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      e_issue: begin
        pf_v_o    = 1'b1;
        pf_addr_o = next_addr_q;
        if (pf_ready_i) begin
          next_addr_d = next_addr_q + entry.stride;
          count_d     = count_q - 1'b1;
          if (count_q == cnt_w_lp'(1)) begin
            state_d = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      count_q     <= '0;
      timer_q     <= '0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      next_addr_q <= next_addr_d;
    end
  end

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// Directed bench: stride training, capped/backpressured issue, stride break,
// zero estimate, timeout edge and asynchronous reset mid-issue.
module tb_bp_be_stride_prefetch_issuer;

  localparam int VW = 39;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_v = 1'b0;
  logic [VW-1:0] ld_pc = '0;
  logic [VW-1:0] ld_eaddr = '0;
  logic          start_discovery, confirm_discovery;
  logic [VW-1:0] striding_pc;
  logic [7:0]    rem_iter = '0;
  logic          v = 1'b0;
  logic          yumi;
  logic          pf_v;
  logic [VW-1:0] pf_addr;
  logic          pf_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_be_stride_prefetch_issuer dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .ld_v_i                (ld_v),
    .ld_pc_i               (ld_pc),
    .ld_eaddr_i            (ld_eaddr),
    .start_discovery_o     (start_discovery),
    .confirm_discovery_o   (confirm_discovery),
    .striding_pc_o         (striding_pc),
    .remaining_iterations_i(rem_iter),
    .v_i                   (v),
    .yumi_o                (yumi),
    .pf_v_o                (pf_v),
    .pf_addr_o             (pf_addr),
    .pf_ready_i            (pf_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one load for the next posedge, returns at the following negedge.
  task automatic load(input logic [VW-1:0] pc, input logic [VW-1:0] addr);
    ld_v = 1'b1; ld_pc = pc; ld_eaddr = addr;
    @(negedge clk);
    ld_v = 1'b0;
  endtask

  task automatic train5(input logic [VW-1:0] pc, input logic [VW-1:0] base, input logic [VW-1:0] stride);
    for (int i = 0; i < 5; i++) load(pc, base + VW'(i) * stride);
  endtask

  initial begin
    int hs;
    int guard;
    logic [VW-1:0] exp_addr;

    repeat (3) @(negedge clk);
    check("rst_start", 64'(start_discovery), 64'd0);
    check("rst_confirm", 64'(confirm_discovery), 64'd0);
    check("rst_yumi", 64'(yumi), 64'd0);
    check("rst_pf_v", 64'(pf_v), 64'd0);
    check("rst_spc", 64'(striding_pc), 64'd0);
    check("rst_pf_addr", 64'(pf_addr), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Stride detection, PC 0x80, stride 8
    load(39'h80, 39'h1000);
    check("spc_train", 64'(striding_pc), 64'h80);
    load(39'h80, 39'h1008);
    check("no_start_1008", 64'(start_discovery), 64'd0);
    load(39'h80, 39'h1010);
    check("start_1010", 64'(start_discovery), 64'd1);
    check("no_confirm_1010", 64'(confirm_discovery), 64'd0);
    load(39'h90, 39'h7777);
    check("start_pulse_ends", 64'(start_discovery), 64'd0);
    load(39'h80, 39'h1018);
    check("no_confirm_1018", 64'(confirm_discovery), 64'd0);
    load(39'h80, 39'h1020);
    check("confirm_1020", 64'(confirm_discovery), 64'd1);
    check("spc_wait", 64'(striding_pc), 64'h80);

    // Capped issue: estimate 5
    v = 1'b1; rem_iter = 8'd5; pf_ready = 1'b1;
    #1 check("yumi_5", 64'(yumi), 64'd1);
    @(negedge clk);
    v = 1'b0;
    check("confirm_pulse_ends", 64'(confirm_discovery), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("pf5_v", 64'(pf_v), 64'd1);
      check("pf5_addr", 64'(pf_addr), 64'h1028 + 64'(i * 8));
      @(negedge clk);
    end
    check("pf5_done", 64'(pf_v), 64'd0);
    check("pf5_idle_spc", 64'(striding_pc), 64'd0);

    // Cap and backpressure: estimate 200 -> 32 handshakes
    train5(39'h100, 39'h2000, 39'h10);
    check("confirm_b", 64'(confirm_discovery), 64'd1);
    v = 1'b1; rem_iter = 8'd200;
    #1 check("yumi_200", 64'(yumi), 64'd1);
    @(negedge clk);
    v = 1'b0;
    hs = 0; guard = 0; exp_addr = 39'h2050;
    while (pf_v && guard < 300) begin
      check("bp_addr", 64'(pf_addr), 64'(exp_addr));
      pf_ready = (guard % 3) != 0;
      if (pf_ready) begin
        exp_addr = exp_addr + 39'h10;
        hs++;
      end
      guard++;
      @(negedge clk);
    end
    check("bp_handshakes", 64'(hs), 64'd32);
    check("bp_done", 64'(pf_v), 64'd0);
    pf_ready = 1'b1;

    // Stride break then second start pulse; zero estimate
    load(39'h200, 39'h3000);
    load(39'h200, 39'h3004);
    check("brk_no_start", 64'(start_discovery), 64'd0);
    load(39'h200, 39'h3008);
    check("brk_start1", 64'(start_discovery), 64'd1);
    load(39'h200, 39'h3010);
    check("brk_reset", 64'(start_discovery), 64'd0);
    load(39'h200, 39'h3018);
    check("brk_start2", 64'(start_discovery), 64'd1);
    load(39'h200, 39'h3020);
    load(39'h200, 39'h3028);
    check("brk_confirm", 64'(confirm_discovery), 64'd1);
    v = 1'b1; rem_iter = 8'd0;
    #1 check("yumi_zero", 64'(yumi), 64'd1);
    @(negedge clk);
    v = 1'b0;
    check("zero_no_pf", 64'(pf_v), 64'd0);
    check("zero_idle", 64'(striding_pc), 64'd0);

    // Timeout with no estimate
    train5(39'h300, 39'h4000, 39'h4);
    check("to_confirm", 64'(confirm_discovery), 64'd1);
    repeat (254) @(negedge clk);
    check("to_still_wait", 64'(striding_pc), 64'h300);
    @(negedge clk);
    check("to_idle", 64'(striding_pc), 64'd0);

    // Estimate arriving on the final timeout cycle wins
    train5(39'h300, 39'h5000, 39'h4);
    repeat (254) @(negedge clk);
    v = 1'b1; rem_iter = 8'd3; pf_ready = 1'b0;
    #1 check("to_last_yumi", 64'(yumi), 64'd1);
    @(negedge clk);
    v = 1'b0;
    check("to_last_pf_v", 64'(pf_v), 64'd1);
    check("to_last_addr", 64'(pf_addr), 64'h5014);

    // Asynchronous reset mid-issue
    #2 reset_n = 1'b0;
    #1;
    check("arst_pf_v", 64'(pf_v), 64'd0);
    check("arst_pf_addr", 64'(pf_addr), 64'd0);
    check("arst_spc", 64'(striding_pc), 64'd0);
    check("arst_yumi", 64'(yumi), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pf_ready = 1'b1;
    @(negedge clk);
    check("post_rst_pf_v", 64'(pf_v), 64'd0);
    check("post_rst_spc", 64'(striding_pc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_be_stride_prefetch_issuer.md
# bp_be_stride_prefetch_issuer

Backend block on the other end of the loop-inference handshake. It watches committed loads, trains a single-entry stride detector and initiates loop-trip discovery with `start_discovery`/`confirm_discovery` and the striding PC. It then consumes the remaining-iteration estimate with a valid/yumi handshake and issues that many stride-ahead prefetch addresses to the D$ prefetch port.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: supplies `vaddr_width_p`.
- `iter_width_p`, 8: width of the remaining-iteration estimate.
- `conf_threshold_p`, 3: consecutive stride repeats required to confirm; legal range ≥1.
- `max_prefetch_p`, 32: cap on prefetches per estimate; legal range ≥1.
- `timeout_p`, 255: cycles to wait for an estimate before abandoning.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `ld_v_i` in 1: committed load valid.
- `ld_pc_i` in `vaddr_width_p`: load PC.
- `ld_eaddr_i` in `vaddr_width_p`: load effective address.
- `start_discovery_o` out 1: one-cycle pulse that begins discovery.
- `confirm_discovery_o` out 1: one-cycle pulse that locks discovery.
- `striding_pc_o` out `vaddr_width_p`: PC of the tracked load.
- `remaining_iterations_i` in `iter_width_p`: trip-count estimate.
- `v_i` in 1: estimate valid.
- `yumi_o` out 1: estimate consumed.
- `pf_v_o` out 1: prefetch request valid.
- `pf_addr_o` out `vaddr_width_p`: prefetch address.
- `pf_ready_i` in 1: prefetch port ready.

## Operation
The block is a state machine with four states: `e_idle`, `e_train`, `e_wait`, `e_issue`.

- **`e_idle`**
  - On `ld_v_i`: latch `pc_r`=`ld_pc_i`, `last_addr_r`=`ld_eaddr_i`, `stride_r`=0, `conf_r`=0.
  - Next state: `e_train`.
- **`e_train`**
  - Loads with PC≠`pc_r` are ignored.
  - On a matching load, compute `new_stride`=`ld_eaddr_i`−`last_addr_r` (modulo 2^vaddr) and set `last_addr_r`=`ld_eaddr_i`.
  - If `new_stride`==`stride_r` and is nonzero: `conf_r`++. Otherwise: `stride_r`=`new_stride`, `conf_r`=0.
  - When `conf_r` goes 0→1: pulse `start_discovery_o`.
  - When `conf_r` reaches `conf_threshold_p`: pulse `confirm_discovery_o`, then go to `e_wait`.
  - If `conf_threshold_p`=1, both pulses assert in the same cycle.
  - A reset of `conf_r` followed by a new 0→1 transition pulses start again.
- **`striding_pc_o`**: equals `pc_r` in every state except `e_idle`; equals 0 in `e_idle`.
- **`e_wait`**
  - `yumi_o`=`v_i` (combinational; every estimate is accepted immediately).
  - Matching loads keep updating `last_addr_r`; `stride_r` is frozen.
  - On `v_i`: `count_r`=min(`remaining_iterations_i`, `max_prefetch_p`) and `next_addr_r`=`last_addr_r`+`stride_r`. If `count_r` would be 0, go to `e_idle`; otherwise go to `e_issue`.
  - The timeout counter increments each cycle while `v_i`=0; at `timeout_p`, go to `e_idle`.
  - If `v_i` arrives on the timeout cycle, `v_i` wins.
- **`e_issue`**
  - `pf_v_o`=1, `pf_addr_o`=`next_addr_r`. Loads are ignored.
  - On `pf_ready_i`: `next_addr_r`+=`stride_r` (wraps), `count_r`−−. A handshake with `count_r`=1 returns to `e_idle`.
  - `pf_addr_o` is held stable while `pf_ready_i`=0.
- **Reset**: `reset_n_i` low at any point immediately clears all state, the counters and every output to 0, including in the middle of issue. The state returns to `e_idle`.

## Timing
- Reset values: `start_discovery_o`, `confirm_discovery_o`, `yumi_o`, `pf_v_o` = 0; `striding_pc_o`, `pf_addr_o` = 0.
- Start and confirm pulses are registered: asserted the cycle after the triggering load, for exactly one cycle.
- `yumi_o` has zero latency relative to `v_i`.
- First `pf_v_o`: the cycle after the `v_i`/`yumi_o` handshake.
- Maximum issue rate: one prefetch per cycle.
- Timeout: exactly `timeout_p` cycles after entering `e_wait` with no `v_i`, the block is back in `e_idle`.

## Structure
- Shared `bp_be_pkg` holds:
  - `bp_be_stride_state_e` (the four states).
  - `bp_be_stride_entry_s` {pc, last_addr, stride, conf}.
- Sub-module `bp_be_stride_tracker`: the training datapath (stride subtract, compare, confidence counter, start/confirm pulse generation).
- The top level holds the FSM, timeout counter, and issue counter/address.

## Test plan
- **Stride detection:** loads to PC 0x80 at 0x1000, 0x1008, 0x1010, 0x1018, 0x1020 -> start pulse one cycle after the 0x1010 load; confirm pulse one cycle after the 0x1020 load; `striding_pc_o`=0x80.
- **Capped issue:** from `e_wait`, present `v_i` with estimate 5 and `pf_ready_i`=1 -> `yumi_o` in the same cycle; 5 prefetches at 0x1028..0x1048 on consecutive cycles; then `e_idle`.
- **Cap and backpressure:** estimate 200, `max_prefetch_p`=32, `pf_ready_i` toggling -> exactly 32 handshakes; address stable during stalls.
- **Stride break and zero estimate:** stride changes after the start pulse -> `conf_r` resets; a second start pulse occurs when the stride repeats again. Separately, estimate 0 -> no `pf_v_o`; return to `e_idle`.
- **Timeout:** no `v_i` for 255 cycles -> `e_idle`. `v_i` arriving on cycle 255 -> accepted.
- **Reset mid-issue:** `reset_n_i` asserted mid-issue -> `pf_v_o` drops asynchronously; all outputs 0.
